// File: rtl/tfacc_ctrl_if.sv
// sr_cpu register bus seen by the tfacc control block.
// Single-cycle bus: rdy is tied high, read data returns one cycle after re.
interface tfacc_ctrl_if;
   logic [31:0] adr;
   logic [3:0]  we;
   logic        re;
   logic        rdy;
   logic [31:0] dw;
   logic [31:0] dr;

   modport master (
      output adr, we, re, dw,
      input  rdy, dr
   );

   modport slave (
      input  adr, we, re, dw,
      output rdy, dr
   );
endinterface

// File: rtl/tfacc_ctrl.sv
// tfacc control/register block: bus decode, kick queue, job sequencing,
// optional auto-flush, sticky done/overflow flags, irq and job cycle count.
module tfacc_ctrl #(
   parameter int Np    = 1,
   parameter int Nbase = 4,
   parameter int Nq    = 2
) (
   input  logic                   clk,
   input  logic                   xrst,
   tfacc_ctrl_if.slave            bus,
   output logic [Nbase-1:0][31:0] baseadr,
   output logic                   kick,
   input  logic                   run,
   output logic                   flreq,
   output logic                   civ,
   input  logic [Np-1:0]          flbsy,
   input  logic [Np-1:0]          o_cmpl,
   output logic [3:0]             monisel,
   output logic                   irq
);

   typedef enum logic [2:0] {
      IDLE, START, WAIT_RUN, RUN, FLUSH, FLWAIT, DONE
   } state_t;

   state_t      state;
   logic [3:0]  qcnt;
   logic        afl, ien, done, ovf;
   logic        fsm_fl, man_fl, fwc;
   logic [31:0] cnt, cycles;
   logic [31:0] rdata;

   logic       wr, hit;
   logic [7:0] off;
   logic       wr_ctrl, wr_mon, wr_stat, wr_cache;
   logic       enq, full, acc, deq, busy;

   assign wr       = |bus.we;
   assign hit      = bus.adr[31:8] == 24'hffff03;
   assign off      = bus.adr[7:0];
   assign wr_ctrl  = wr & hit & (off == 8'h00);
   assign wr_mon   = wr & hit & (off == 8'h20);
   assign wr_stat  = wr & hit & (off == 8'h24);
   assign wr_cache = bus.we[3] & (bus.adr == 32'hffff0180);

   assign enq  = wr_ctrl & bus.dw[0];
   assign full = qcnt == 4'(Nq);
   assign acc  = enq & ~full;
   assign deq  = state == START;
   assign busy = state != IDLE;

   assign bus.rdy = 1'b1;
   assign flreq   = fsm_fl | man_fl;
   assign irq     = ien & done;

   always_comb begin
      rdata = '0;
      if (hit) begin
         case (off)
            8'h00: rdata = {20'h0, qcnt, 4'h0, ien, afl, busy, run};
            8'h1c: rdata = 32'(Np);
            8'h20: rdata = {28'h0, monisel};
            8'h24: rdata = {30'h0, ovf, done};
            8'h28: rdata = cycles;
            default: ;
         endcase
         for (int i = 0; i < Nbase; i++)
            if (off == 8'(4 + 4 * i))
               rdata = baseadr[i];
      end
      if (bus.adr == 32'hffff0180)
         rdata = {|flbsy, &o_cmpl, 30'h0};
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         baseadr <= '0;
         monisel <= '0;
         afl     <= 1'b0;
         ien     <= 1'b0;
         qcnt    <= '0;
         ovf     <= 1'b0;
         civ     <= 1'b0;
         man_fl  <= 1'b0;
         bus.dr  <= '0;
      end else begin
         bus.dr <= bus.re ? rdata : '0;
         civ    <= wr_cache & bus.dw[24];
         man_fl <= wr_cache & bus.dw[31];
         if (wr_ctrl) begin
            afl <= bus.dw[1];
            ien <= bus.dw[2];
         end
         if (wr_mon)
            monisel <= bus.dw[3:0];
         for (int i = 0; i < Nbase; i++)
            if (wr & hit & (off == 8'(4 + 4 * i)))
               baseadr[i] <= bus.dw;
         if (acc & ~deq)
            qcnt <= qcnt + 4'd1;
         else if (deq & ~acc)
            qcnt <= qcnt - 4'd1;
         // a dropped kick beats a simultaneous clear
         if (enq & full)
            ovf <= 1'b1;
         else if (wr_stat & bus.dw[1])
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state  <= IDLE;
         kick   <= 1'b0;
         fsm_fl <= 1'b0;
         fwc    <= 1'b0;
         cnt    <= '0;
         cycles <= '0;
         done   <= 1'b0;
      end else begin
         kick   <= 1'b0;
         fsm_fl <= 1'b0;
         if (state == START)
            cnt <= 32'd1;
         else if (busy && !(&cnt))
            cnt <= cnt + 32'd1;
         if (state == DONE)
            done <= 1'b1;
         else if (wr_stat & bus.dw[0])
            done <= 1'b0;
         unique case (state)
            IDLE:
               if (qcnt != 4'd0) begin
                  state <= START;
                  kick  <= 1'b1;
               end
            START:
               state <= WAIT_RUN;
            WAIT_RUN:
               if (run)
                  state <= RUN;
            RUN:
               if (!run) begin
                  if (afl) begin
                     state  <= FLUSH;
                     fsm_fl <= 1'b1;
                  end else begin
                     state <= DONE;
                  end
               end
            FLUSH: begin
               state <= FLWAIT;
               fwc   <= 1'b0;
            end
            // first FLWAIT cycle never exits so flbsy has time to rise
            FLWAIT:
               if (!fwc)
                  fwc <= 1'b1;
               else if (!(|flbsy) && (&o_cmpl))
                  state <= DONE;
            DONE: begin
               state  <= IDLE;
               cycles <= (&cnt) ? cnt : cnt + 32'd1;
            end
            default:
               state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tfacc_ctrl.sv
// Directed bench for tfacc_ctrl: register access, job sequencing,
// auto-flush/irq, queue overflow, set-vs-clear and mid-job reset.
module tb_tfacc_ctrl;
   localparam int Np    = 1;
   localparam int Nbase = 4;
   localparam int Nq    = 2;

   localparam logic [31:0] A_CTRL  = 32'hffff0300;
   localparam logic [31:0] A_NP    = 32'hffff031c;
   localparam logic [31:0] A_MON   = 32'hffff0320;
   localparam logic [31:0] A_STAT  = 32'hffff0324;
   localparam logic [31:0] A_CYC   = 32'hffff0328;
   localparam logic [31:0] A_CACHE = 32'hffff0180;

   logic                   clk = 1'b0;
   logic                   xrst;
   logic [Nbase-1:0][31:0] baseadr;
   logic                   kick, run, flreq, civ, irq;
   logic [Np-1:0]          flbsy, o_cmpl;
   logic [3:0]             monisel;

   tfacc_ctrl_if bus ();

   tfacc_ctrl #(.Np(Np), .Nbase(Nbase), .Nq(Nq)) dut (
      .clk     (clk),
      .xrst    (xrst),
      .bus     (bus),
      .baseadr (baseadr),
      .kick    (kick),
      .run     (run),
      .flreq   (flreq),
      .civ     (civ),
      .flbsy   (flbsy),
      .o_cmpl  (o_cmpl),
      .monisel (monisel),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   int nerr = 0;
   int nchk = 0;
   int nkick = 0;
   int nfl = 0;

   always @(negedge clk) begin
      if (kick) nkick++;
      if (flreq) nfl++;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] w);
      bus.adr = a;
      bus.dw  = d;
      bus.we  = w;
      tick();
      bus.we  = 4'h0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.adr = a;
      bus.re  = 1'b1;
      tick();
      bus.re  = 1'b0;
      d = bus.dr;
   endtask

   task automatic wait_kick();
      int n = 0;
      while (!kick && n < 40) begin
         tick();
         n++;
      end
      check("kick_seen", {31'h0, kick}, 32'd1);
   endtask

   task automatic job(input int w, input int r);
      wait_kick();
      repeat (w) tick();
      run = 1'b1;
      repeat (r) tick();
      run = 1'b0;
   endtask

   logic [31:0] d;
   int k0, f0, n;

   initial begin
      xrst    = 1'b0;
      bus.adr = '0;
      bus.dw  = '0;
      bus.we  = '0;
      bus.re  = 1'b0;
      run     = 1'b0;
      flbsy   = '0;
      o_cmpl  = '1;
      tick();
      tick();
      xrst = 1'b1;
      tick();

      check("rst_dr", bus.dr, 32'h0);
      check("rst_outs", {27'h0, kick, flreq, civ, irq, |baseadr},
            32'h0);
      check("rst_mon", {28'h0, monisel}, 32'h0);
      check("rdy", {31'h0, bus.rdy}, 32'd1);
      rd(A_CTRL, d);  check("rst_ctrl", d, 32'h0);
      rd(A_STAT, d);  check("rst_stat", d, 32'h0);
      rd(A_CYC, d);   check("rst_cyc", d, 32'h0);

      for (int i = 0; i < 4; i++)
         wr(32'hffff0304 + 32'(4 * i), 32'h1000 * 32'(i + 1), 4'hf);
      wr(A_MON, 32'h5, 4'hf);
      for (int i = 0; i < 4; i++) begin
         rd(32'hffff0304 + 32'(4 * i), d);
         check("base_rd", d, 32'h1000 * 32'(i + 1));
         check("base_port", baseadr[i], 32'h1000 * 32'(i + 1));
      end
      rd(A_MON, d);   check("mon_rd", d, 32'h5);
      tick();
      check("dr_idle0", bus.dr, 32'h0);
      check("mon_port", {28'h0, monisel}, 32'h5);
      rd(A_NP, d);    check("np_rd", d, 32'(Np));
      rd(32'hffff0330, d); check("unmapped", d, 32'h0);
      rd(32'hffff0314, d); check("base_oob", d, 32'h0);
      rd(A_CACHE, d); check("cache_rd", d, 32'h4000_0000);

      f0 = nfl;
      wr(A_CACHE, 32'h8100_0000, 4'h8);
      check("civ_hi", {31'h0, civ}, 32'd1);
      check("mfl_hi", {31'h0, flreq}, 32'd1);
      tick();
      check("civ_lo", {31'h0, civ}, 32'd0);
      check("mfl_cnt", nfl - f0, 32'd1);

      // single job, no auto-flush
      k0 = nkick;
      f0 = nfl;
      wr(A_CTRL, 32'h1, 4'hf);
      job(3, 10);
      tick();
      tick();
      rd(A_STAT, d);  check("j1_done", d, 32'h1);
      rd(A_CYC, d);   check("j1_cycles", d, 32'd15);
      check("j1_kicks", nkick - k0, 32'd1);
      check("j1_noflush", nfl - f0, 32'd0);
      check("j1_irq", {31'h0, irq}, 32'd0);
      wr(A_STAT, 32'h1, 4'hf);
      rd(A_STAT, d);  check("j1_clr", d, 32'h0);

      // auto-flush with interrupt
      f0 = nfl;
      wr(A_CTRL, 32'h7, 4'hf);
      job(1, 2);
      n = 0;
      while (!flreq && n < 20) begin
         tick();
         n++;
      end
      check("fl_seen", {31'h0, flreq}, 32'd1);
      tick();
      flbsy = '1;
      for (int i = 0; i < 5; i++) begin
         check("fl_irq_busy", {31'h0, irq}, 32'd0);
         tick();
      end
      flbsy = '0;
      check("fl_irq_a", {31'h0, irq}, 32'd0);
      tick();
      check("fl_irq_b", {31'h0, irq}, 32'd0);
      tick();
      check("fl_irq", {31'h0, irq}, 32'd1);
      check("fl_pulses", nfl - f0, 32'd1);
      rd(A_CYC, d);   check("fl_cycles", d, 32'd12);
      wr(A_STAT, 32'h1, 4'hf);
      check("irq_clr", {31'h0, irq}, 32'd0);

      // queue overflow
      k0 = nkick;
      wr(A_CTRL, 32'h1, 4'hf);
      wait_kick();
      tick();
      run = 1'b1;
      tick();
      repeat (3) wr(A_CTRL, 32'h1, 4'hf);
      rd(A_CTRL, d);  check("q_ctrl", d, 32'h0000_0203);
      rd(A_STAT, d);  check("q_ovf", d, 32'h2);
      run = 1'b0;
      job(2, 3);
      job(2, 3);
      repeat (12) tick();
      check("q_kicks", nkick - k0, 32'd3);
      rd(A_CTRL, d);  check("q_empty", d, 32'h0);

      // W1C of done in the DONE cycle
      wr(A_STAT, 32'h3, 4'hf);
      wr(A_CTRL, 32'h1, 4'hf);
      job(1, 1);
      tick();
      wr(A_STAT, 32'h1, 4'hf);
      rd(A_STAT, d);  check("set_wins", d, 32'h1);
      rd(A_CYC, d);   check("sw_cycles", d, 32'd4);

      // reset in the middle of a job with one kick queued
      wr(A_CTRL, 32'h1, 4'hf);
      wait_kick();
      tick();
      run = 1'b1;
      tick();
      wr(A_CTRL, 32'h1, 4'hf);
      #2;
      xrst = 1'b0;
      run  = 1'b0;
      #1;
      check("mr_outs", {27'h0, kick, flreq, civ, irq, |baseadr},
            32'h0);
      check("mr_dr", bus.dr, 32'h0);
      check("mr_mon", {28'h0, monisel}, 32'h0);
      tick();
      xrst = 1'b1;
      k0 = nkick;
      repeat (10) tick();
      check("mr_nokick", nkick - k0, 32'd0);
      rd(A_CTRL, d);  check("mr_ctrl", d, 32'h0);
      rd(A_STAT, d);  check("mr_stat", d, 32'h0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=0", 1);
      $fatal(1);
   end
endmodule

// File: doc/tfacc_ctrl.md
# tfacc_ctrl

Parametrised control and register block for the tfacc accelerator. It decodes the sr_cpu register bus and holds the base-address and monitor registers. It queues kick requests and sequences each job through run, optional automatic output-cache flush and completion. On completion it raises a sticky done flag, an interrupt and a per-job cycle count. It sits between the sr_cpu bus and the address generator and caches inside the accelerator core, and it adds job queueing, auto-flush and interrupt support.

## Interface
- Np, 1, parallel channel count (flbsy/o_cmpl width; reported at 0xffff031c)
- Nbase, 4, number of base-address registers (1..6)
- Nq, 2, kick queue depth (1..15)
- clk  in  1  clock
- xrst  in  1  reset; one clock, reset asynchronous and active-low
- adr  in  32  sr_cpu byte address
- we  in  4  byte write enables
- re  in  1  read enable
- rdy  out  1  bus ready, constant 1
- dw  in  32  write data
- dr  out  32  read data, registered
- baseadr  out  Nbase x 32  base addresses (index 0 out, 1 in, 2 filter, 3 bias, rest spare)
- kick  out  1  one-cycle start pulse to address generator
- run  in  1  address generator running flag
- flreq  out  1  one-cycle output-cache flush pulse
- civ  out  1  one-cycle cache invalidate pulse
- flbsy  in  Np  per-channel flush busy
- o_cmpl  in  Np  per-channel output complete
- monisel  out  4  monitor select
- irq  out  1  level interrupt

## Operation
- Write decode: any we bit set. Read decode: re.
- Register map (word addresses):
  - 0xffff0300 CTRL:
    - write: bit0 enqueue kick, bit1 auto-flush enable (afl), bit2 irq enable (ien). Bits 2:1 are stored.
    - read: {20'h0, qcnt[3:0], 4'h0, ien, afl, busy, run}. busy = state != IDLE.
  - 0xffff0304+4i baseadr[i], i < Nbase, read/write. Addresses beyond Nbase read 0 and ignore writes.
  - 0xffff031c: reads Np.
  - 0xffff0320 monisel, read/write dw[3:0].
  - 0xffff0324 STATUS:
    - read: {30'h0, ovf, done}.
    - write-1-to-clear per bit.
  - 0xffff0328 CYCLES, read-only: cycle count of the last completed job.
  - 0xffff0180 cache register:
    - write with we[3]: dw[31] gives a manual flreq pulse, dw[24] gives a civ pulse.
    - read: {|flbsy, &o_cmpl, 30'h0}.
- All other addresses read 0.
- Kick queue: qcnt counter, range 0..Nq.
  - A kick write when qcnt == Nq is dropped and sets ovf.
  - An enqueue and a dequeue in the same cycle leave qcnt unchanged.
- FSM states:
  - IDLE: if qcnt > 0, go to START.
  - START: kick = 1, qcnt decrements, cycle counter cleared to 1. Go to WAIT_RUN.
  - WAIT_RUN: go to RUN when run = 1.
  - RUN: when run = 0, go to FLUSH if afl, else DONE.
  - FLUSH: flreq = 1. Go to FLWAIT.
  - FLWAIT: stay at least 2 cycles, then go to DONE when flbsy == 0 and &o_cmpl.
  - DONE: set done, latch counter+1 into CYCLES. Go to IDLE.
- Cycle counter increments every cycle outside IDLE and saturates at 0xffffffff.
- flreq = FSM flush | manual flush (OR of both).
- irq = ien & done.

## Timing
- Reset values: dr 0, kick 0, flreq 0, civ 0, irq 0, baseadr all 0, monisel 0, qcnt 0, afl 0, ien 0, done 0, ovf 0, CYCLES 0, state IDLE.
- Register writes take effect on the next clock edge.
- Read data appears on dr the cycle after re and is 0 otherwise.
- Kick latency: a CTRL kick write at edge n with the FSM idle gives qcnt = 1 after n; kick is high for cycle n+1 (START), then the FSM is in WAIT_RUN.
- civ and manual flreq are high exactly one cycle, the cycle after the write edge.
- Job length: CYCLES counts cycles from START through DONE inclusive.
- Simultaneous events:
  - done set in DONE together with a W1C clear: set wins.
  - ovf set together with clear: set wins.
- No timeout in WAIT_RUN or FLWAIT. Recovery is by reset only.
- Reset mid-job: asynchronous return to reset values and IDLE; queued kicks are discarded.
- In steady state a new job starts one cycle after DONE if qcnt > 0, i.e. IDLE is visited for one cycle.

## Test plan
- Register access:
  - write baseadr[0..3] = 0x1000, 0x2000, 0x3000, 0x4000 and monisel = 5;
  - read back: same values one cycle after re;
  - read 0xffff031c returns Np; read of 0xffff0330 returns 0.
- Single job, afl = 0:
  - kick; model run high 3 cycles after kick for 10 cycles;
  - required: one kick pulse, done = 1, CYCLES = 15 (START 1 + WAIT_RUN 3 + RUN 10 + DONE 1), irq stays 0 since ien = 0.
- Auto-flush with ien = 1:
  - flbsy high 5 cycles starting 1 cycle after flreq, o_cmpl all 1;
  - required: exactly one flreq pulse, DONE only after flbsy drops, irq = 1;
  - W1C of done drops irq the next cycle.
- Queue overflow, Nq = 2:
  - 3 kick writes while the FSM is in RUN;
  - required: qcnt = 2, ovf = 1, and exactly 2 further kick pulses in the following jobs.
- Simultaneous clear and set: W1C done written in the DONE cycle -> done reads 1.
- Reset mid-RUN with qcnt = 1: deassert xrst -> all outputs 0, no kick after reset release, CTRL reads 0.
